// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin CPU/DMA arbiter in front of a single-port data memory
module mem_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ACCESS   = 2'd1;
  localparam logic [1:0] COMPLETE = 2'd2;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  logic [1:0]        state;
  logic              we_l;
  logic              owner;
  logic              last_owner;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] dma_rdata_q;
  logic              grant_valid;
  logic              grant;

  // In COMPLETE only the non-owner may be granted, so a held owner req is not served twice.
  always_comb begin
    grant_valid = 1'b0;
    grant       = OWN_CPU;
    case (state)
      IDLE: begin
        if (cpu_req && dma_req) begin
          grant_valid = 1'b1;
          grant       = ~last_owner;
        end else if (cpu_req) begin
          grant_valid = 1'b1;
          grant       = OWN_CPU;
        end else if (dma_req) begin
          grant_valid = 1'b1;
          grant       = OWN_DMA;
        end
      end
      COMPLETE: begin
        if (owner == OWN_CPU && dma_req) begin
          grant_valid = 1'b1;
          grant       = OWN_DMA;
        end else if (owner == OWN_DMA && cpu_req) begin
          grant_valid = 1'b1;
          grant       = OWN_CPU;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      we_l        <= 1'b0;
      owner       <= OWN_CPU;
      last_owner  <= OWN_DMA;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      if (state == COMPLETE) begin
        last_owner <= owner;
        if (!we_l && owner == OWN_CPU) cpu_rdata_q <= mem_rdata;
        if (!we_l && owner == OWN_DMA) dma_rdata_q <= mem_rdata;
      end
      if (grant_valid) begin
        state     <= ACCESS;
        owner     <= grant;
        we_l      <= (grant == OWN_DMA) ? dma_we    : cpu_we;
        mem_addr  <= (grant == OWN_DMA) ? dma_addr  : cpu_addr;
        mem_wdata <= (grant == OWN_DMA) ? dma_wdata : cpu_wdata;
      end else if (state == ACCESS) begin
        state <= COMPLETE;
      end else begin
        state <= IDLE;
      end
    end
  end

  assign mem_read  = (state == ACCESS) && !we_l;
  assign mem_write = (state == ACCESS) && we_l;
  assign cpu_ack   = (state == COMPLETE) && (owner == OWN_CPU);
  assign dma_ack   = (state == COMPLETE) && (owner == OWN_DMA);
  assign cpu_stall = cpu_req && !cpu_ack;

  // Load data is forwarded straight from memory in the ack cycle, then held.
  assign cpu_rdata = (cpu_ack && !we_l) ? mem_rdata : cpu_rdata_q;
  assign dma_rdata = (dma_ack && !we_l) ? mem_rdata : dma_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [12:0] cpu_addr, dma_addr, mem_addr;
  logic [31:0] cpu_wdata, dma_wdata, cpu_rdata, dma_rdata, mem_wdata, mem_rdata;
  logic        cpu_ack, cpu_stall, dma_ack, mem_read, mem_write;

  logic [31:0] mem [0:8191];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(13), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Data memory with one-cycle registered read.
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_wdata;
    if (mem_read) mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic flags(input string tag, input logic rd, input logic wr, input logic ca, input logic da);
    check({tag, " mem_read"},  32'(mem_read),  32'(rd));
    check({tag, " mem_write"}, 32'(mem_write), 32'(wr));
    check({tag, " cpu_ack"},   32'(cpu_ack),   32'(ca));
    check({tag, " dma_ack"},   32'(dma_ack),   32'(da));
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cpu_set(input logic req, input logic we, input logic [12:0] a, input logic [31:0] d);
    cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic dma_set(input logic req, input logic we, input logic [12:0] a, input logic [31:0] d);
    dma_req = req; dma_we = we; dma_addr = a; dma_wdata = d;
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 32'd0;
    mem[13'h0010] = 32'hDEADBEEF;
    mem_rdata = 32'd0;
    rst = 1'b1;
    cpu_set(1'b0, 1'b0, 13'd0, 32'd0);
    dma_set(1'b0, 1'b0, 13'd0, 32'd0);
    tick;
    tick;
    flags("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset cpu_rdata", cpu_rdata, 32'd0);
    check("reset dma_rdata", dma_rdata, 32'd0);
    check("reset mem_addr", 32'(mem_addr), 32'd0);
    rst = 1'b0;
    tick;

    // Single CPU load
    cpu_set(1'b1, 1'b0, 13'h0010, 32'd0);
    #1 check("load stall N", 32'(cpu_stall), 32'd1);
    tick;
    flags("load access", 1'b1, 1'b0, 1'b0, 1'b0);
    check("load mem_addr", 32'(mem_addr), 32'h0010);
    check("load stall N+1", 32'(cpu_stall), 32'd1);
    tick;
    flags("load complete", 1'b0, 1'b0, 1'b1, 1'b0);
    check("load cpu_rdata", cpu_rdata, 32'hDEADBEEF);
    check("load stall ack", 32'(cpu_stall), 32'd0);
    cpu_req = 1'b0;
    tick;
    flags("load idle", 1'b0, 1'b0, 1'b0, 1'b0);
    check("load rdata held", cpu_rdata, 32'hDEADBEEF);

    // Single DMA store at the top address
    dma_set(1'b1, 1'b1, 13'h1FFF, 32'h12345678);
    tick;
    flags("store access", 1'b0, 1'b1, 1'b0, 1'b0);
    check("store mem_addr", 32'(mem_addr), 32'h1FFF);
    check("store mem_wdata", mem_wdata, 32'h12345678);
    tick;
    flags("store complete", 1'b0, 1'b0, 1'b0, 1'b1);
    check("store dma_rdata kept", dma_rdata, 32'd0);
    dma_req = 1'b0;
    tick;
    flags("store idle", 1'b0, 1'b0, 1'b0, 1'b0);
    cpu_set(1'b1, 1'b0, 13'h1FFF, 32'd0);
    tick;
    tick;
    check("readback ack", 32'(cpu_ack), 32'd1);
    check("readback data", cpu_rdata, 32'h12345678);
    cpu_req = 1'b0;
    tick;

    // Simultaneous requests right after reset: CPU first, DMA with no gap
    rst = 1'b1;
    tick;
    rst = 1'b0;
    cpu_set(1'b1, 1'b0, 13'h0010, 32'd0);
    dma_set(1'b1, 1'b0, 13'h1FFF, 32'd0);
    tick;
    flags("tie N+1", 1'b1, 1'b0, 1'b0, 1'b0);
    check("tie addr N+1", 32'(mem_addr), 32'h0010);
    tick;
    flags("tie N+2", 1'b0, 1'b0, 1'b1, 1'b0);
    check("tie cpu_rdata", cpu_rdata, 32'hDEADBEEF);
    cpu_req = 1'b0;
    tick;
    flags("tie N+3", 1'b1, 1'b0, 1'b0, 1'b0);
    check("tie addr N+3", 32'(mem_addr), 32'h1FFF);
    tick;
    flags("tie N+4", 1'b0, 1'b0, 1'b0, 1'b1);
    check("tie dma_rdata", dma_rdata, 32'h12345678);
    dma_req = 1'b0;
    tick;
    flags("tie idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Both held for 8 transactions: strict alternation starting with CPU
    cpu_set(1'b1, 1'b0, 13'h0010, 32'd0);
    dma_set(1'b1, 1'b0, 13'h1FFF, 32'd0);
    for (int i = 1; i <= 16; i++) begin
      tick;
      if (i % 2 == 1) begin
        flags($sformatf("rr %0d", i), 1'b1, 1'b0, 1'b0, 1'b0);
        check($sformatf("rr addr %0d", i), 32'(mem_addr), (i % 4 == 1) ? 32'h0010 : 32'h1FFF);
      end else begin
        flags($sformatf("rr %0d", i), 1'b0, 1'b0, (i % 4 == 2), (i % 4 == 0));
      end
    end
    cpu_req = 1'b0;
    dma_req = 1'b0;
    tick;
    flags("rr idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset in the ACCESS cycle of a CPU store aborts it
    cpu_set(1'b1, 1'b1, 13'h0020, 32'hCAFEF00D);
    tick;
    flags("abort access", 1'b0, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    flags("abort in reset", 1'b0, 1'b0, 1'b0, 1'b0);
    check("abort mem_addr", 32'(mem_addr), 32'd0);
    check("abort mem_wdata", mem_wdata, 32'd0);
    check("abort cpu_rdata", cpu_rdata, 32'd0);
    tick;
    flags("abort held", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick;
    flags("retry access", 1'b0, 1'b1, 1'b0, 1'b0);
    check("retry mem_addr", 32'(mem_addr), 32'h0020);
    tick;
    flags("retry complete", 1'b0, 1'b0, 1'b1, 1'b0);
    cpu_set(1'b0, 1'b0, 13'h0020, 32'd0);
    tick;
    cpu_req = 1'b1;
    tick;
    tick;
    check("retry readback", cpu_rdata, 32'hCAFEF00D);

    // Held req through its ack: one ack, then a fresh pass through IDLE
    cpu_set(1'b0, 1'b0, 13'h0010, 32'd0);
    tick;
    cpu_req = 1'b1;
    tick;
    flags("hold 1", 1'b1, 1'b0, 1'b0, 1'b0);
    tick;
    flags("hold 2", 1'b0, 1'b0, 1'b1, 1'b0);
    tick;
    flags("hold 3 idle", 1'b0, 1'b0, 1'b0, 1'b0);
    tick;
    flags("hold 4", 1'b1, 1'b0, 1'b0, 1'b0);
    tick;
    flags("hold 5", 1'b0, 1'b0, 1'b1, 1'b0);
    check("hold rdata", cpu_rdata, 32'hDEADBEEF);
    cpu_req = 1'b0;
    tick;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
